// File: rtl/pipe_mux_tree.sv
// Pipelined WIDTH-bit CHANNELS:1 select tree with valid/ready handshake and flush.
// Optional range check of in_sel (reported on out_err) enabled by PIPE_MUX_RANGE_CHECK_EN.
module pipe_mux_tree #(
    parameter int unsigned CHANNELS  = 64,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned REG_EVERY = 2,
    localparam int unsigned LEVELS   = $clog2(CHANNELS),
    localparam int unsigned SW       = LEVELS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SW-1:0]             in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_err,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned NLEAF = 2 ** LEVELS;
    localparam int unsigned LAT   = (LEVELS + REG_EVERY - 1) / REG_EVERY;

    logic [LAT:0] w_ready;

    assign w_ready[LAT] = out_ready;
    assign in_ready     = w_ready[0] && !flush;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int unsigned LS    = s * REG_EVERY;
        localparam int unsigned LE    = (LS + REG_EVERY < LEVELS) ? LS + REG_EVERY : LEVELS;
        localparam int unsigned NL    = LE - LS;
        localparam int unsigned IN_N  = NLEAF >> LS;
        localparam int unsigned OUT_N = NLEAF >> LE;
        localparam int unsigned SI    = LEVELS - LS;
        localparam int unsigned SO    = LEVELS - LE;

        logic [IN_N*WIDTH-1:0]  w_din;
        logic [SI-1:0]          w_sin;
        logic                   w_vin;
        logic                   w_ld;
        logic [WIDTH-1:0]       w_node [NL+1][IN_N];
        logic [OUT_N*WIDTH-1:0] w_dout;
        logic [OUT_N*WIDTH-1:0] r_data;
        logic                   r_valid;

        // Stage 0 is fed directly from the ports; leaves past CHANNELS are zero.
        if (s == 0) begin : g_src
            assign w_din = (IN_N*WIDTH)'(in_data);
            assign w_sin = in_sel;
            assign w_vin = in_valid && in_ready;
        end else begin : g_src
            assign w_din = g_stage[s-1].r_data;
            assign w_sin = g_stage[s-1].g_sel.r_sel;
            assign w_vin = g_stage[s-1].r_valid;
        end

        assign w_ld       = !flush && w_ready[s] && w_vin;
        assign w_ready[s] = !r_valid || w_ready[s+1];

        // Levels LS..LE-1 of the tree, select bit l of the remaining select at local level l.
        always_comb begin
            for (int l = 0; l <= int'(NL); l++) begin
                for (int j = 0; j < int'(IN_N); j++) begin
                    w_node[l][j] = '0;
                end
            end
            for (int j = 0; j < int'(IN_N); j++) begin
                w_node[0][j] = w_din[j*WIDTH +: WIDTH];
            end
            for (int l = 0; l < int'(NL); l++) begin
                for (int j = 0; j < int'(IN_N >> (l + 1)); j++) begin
                    w_node[l+1][j] = w_sin[l] ? w_node[l][2*j+1] : w_node[l][2*j];
                end
            end
        end

        always_comb begin
            w_dout = '0;
            for (int j = 0; j < int'(OUT_N); j++) begin
                w_dout[j*WIDTH +: WIDTH] = w_node[NL][j];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (w_ready[s]) begin
                r_valid <= w_vin;
                if (w_vin) begin
                    r_data <= w_dout;
                end
            end
        end

        // Upper select bits travel with the beat to the levels still ahead.
        if (SO > 0) begin : g_sel
            logic [SO-1:0] r_sel;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sel <= '0;
                end else if (w_ld) begin
                    r_sel <= w_sin[SI-1:NL];
                end
            end
        end

`ifdef PIPE_MUX_RANGE_CHECK_EN
        logic w_ein;
        logic r_err;
        if (s == 0) begin : g_err_src
            assign w_ein = {1'b0, in_sel} >= (SW+1)'(CHANNELS);
        end else begin : g_err_src
            assign w_ein = g_stage[s-1].r_err;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_err <= 1'b0;
            end else if (w_ld) begin
                r_err <= w_ein;
            end
        end
`endif
    end

    assign out_data  = g_stage[LAT-1].r_data;
    assign out_valid = g_stage[LAT-1].r_valid;
`ifdef PIPE_MUX_RANGE_CHECK_EN
    assign out_err   = g_stage[LAT-1].r_err;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux_tree.sv
// Directed bench for pipe_mux_tree: 64-channel stream/backpressure/flush/reset and a 5-channel range case.
module tb_pipe_mux_tree;

    localparam int unsigned CH  = 64;
    localparam int unsigned W   = 8;
    localparam int          LAT = 3;
    localparam int unsigned CH5 = 5;
`ifdef PIPE_MUX_RANGE_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [CH*W-1:0] in_data64;
    logic [5:0]      sel64;
    logic            vld64, rdy64, fl64;
    logic            in_ready64, out_valid64, out_err64;
    logic [W-1:0]    out_data64;

    logic [CH5*W-1:0] in_data5;
    logic [2:0]       sel5;
    logic             vld5, rdy5, fl5;
    logic             in_ready5, out_valid5, out_err5;
    logic [W-1:0]     out_data5;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_del    = 0;
    bit chk_lat  = 1'b0;
    logic [7:0] exp_q[$];
    int         acc_q[$];

    always #5 clk = ~clk;

    pipe_mux_tree #(.CHANNELS(CH), .WIDTH(W), .REG_EVERY(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data64), .in_sel(sel64),
        .in_valid(vld64), .in_ready(in_ready64), .flush(fl64),
        .out_data(out_data64), .out_err(out_err64), .out_valid(out_valid64),
        .out_ready(rdy64)
    );

    pipe_mux_tree #(.CHANNELS(CH5), .WIDTH(W), .REG_EVERY(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_sel(sel5),
        .in_valid(vld5), .in_ready(in_ready5), .flush(fl5),
        .out_data(out_data5), .out_err(out_err5), .out_valid(out_valid5),
        .out_ready(rdy5)
    );

    // One clock of the 64-channel DUT with scoreboard bookkeeping; called at posedge+1.
    task automatic tick();
        logic [7:0] e;
        int a;
        bit acc;
        #1;
        if (fl64) begin
            n_checks++;
            if (in_ready64 !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_in_ready: got %b want 0", in_ready64);
            end
        end
        acc = vld64 && in_ready64;
        if (acc) begin
            exp_q.push_back(8'(sel64) + 8'd1);
            acc_q.push_back(cyc);
            n_acc++;
        end
        if (out_valid64 && rdy64) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got data %0d want no beat", out_data64);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                n_del++;
                if (out_data64 !== e || out_err64 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL beat_data: got %0d err %b want %0d err 0", out_data64, out_err64, e);
                end
                if (chk_lat) begin
                    n_checks++;
                    if (cyc - a != LAT) begin
                        n_fail++;
                        $display("FAIL latency: got %0d want %0d", cyc - a, LAT);
                    end
                end
            end
        end
        if (fl64) begin
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) sel64 = sel64 + 6'd1;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            tick();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d beats left want 0", nm, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (out_valid64 !== 1'b0 || out_data64 !== 8'd0 || out_err64 !== 1'b0 || out_valid5 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%0d e=%b v5=%b want 0 0 0 0",
                     out_valid64, out_data64, out_err64, out_valid5);
        end
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready64 !== 1'b1 || in_ready5 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready64, in_ready5);
        end
    endtask

    task automatic test_stream();
        int base_acc, base_del, k;
        base_acc = n_acc;
        base_del = n_del;
        sel64 = 6'd0; vld64 = 1'b1; rdy64 = 1'b1; chk_lat = 1'b1;
        k = 0;
        while (n_acc - base_acc < 64 && k < 100) begin
            tick();
            k++;
        end
        vld64 = 1'b0;
        n_checks++;
        if (k != 64) begin
            n_fail++;
            $display("FAIL stream_throughput: got %0d cycles want 64", k);
        end
        drain("stream");
        n_checks++;
        if (n_del - base_del != 64) begin
            n_fail++;
            $display("FAIL stream_count: got %0d want 64", n_del - base_del);
        end
        chk_lat = 1'b0;
    endtask

    task automatic test_backpressure();
        int base_acc, base_del;
        base_acc = n_acc;
        base_del = n_del;
        sel64 = 6'd10; vld64 = 1'b1; rdy64 = 1'b1;
        tick();
        tick();
        rdy64 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (n_acc - base_acc != 3 || in_ready64 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_held: got %0d beats in_ready=%b want 3 beats in_ready=0",
                     n_acc - base_acc, in_ready64);
        end
        n_checks++;
        if (out_valid64 !== 1'b1 || out_data64 !== 8'd11) begin
            n_fail++;
            $display("FAIL bp_head: got v=%b d=%0d want v=1 d=11", out_valid64, out_data64);
        end
        rdy64 = 1'b1;
        tick();
        tick();
        vld64 = 1'b0;
        drain("bp");
        n_checks++;
        if (n_del - base_del != n_acc - base_acc || n_acc - base_acc != 5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d delivered of %0d want 5 of 5",
                     n_del - base_del, n_acc - base_acc);
        end
    endtask

    task automatic test_flush();
        int k, base_del;
        sel64 = 6'd20; vld64 = 1'b1; rdy64 = 1'b0;
        k = 0;
        while (in_ready64 && k < 10) begin
            tick();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL flush_fill: got %0d beats want 3", exp_q.size());
        end
        fl64 = 1'b1;
        tick();
        fl64 = 1'b0; vld64 = 1'b0;
        #1;
        n_checks++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b in_ready=%b want 0 1", out_valid64, in_ready64);
        end
        base_del = n_del;
        sel64 = 6'd30; vld64 = 1'b1; rdy64 = 1'b1; chk_lat = 1'b1;
        tick();
        vld64 = 1'b0;
        drain("flush");
        n_checks++;
        if (n_del - base_del != 1) begin
            n_fail++;
            $display("FAIL flush_after: got %0d beats want 1", n_del - base_del);
        end
        chk_lat = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k, base_del;
        sel64 = 6'd40; vld64 = 1'b1; rdy64 = 1'b0;
        k = 0;
        while (in_ready64 && k < 10) begin
            tick();
            k++;
        end
        n_checks++;
        if (out_valid64 !== 1'b1 || out_data64 !== 8'd41) begin
            n_fail++;
            $display("FAIL rst_pre: got v=%b d=%0d want v=1 d=41", out_valid64, out_data64);
        end
        vld64 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid64 !== 1'b0 || out_data64 !== 8'd0 || out_err64 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b d=%0d e=%b want 0 0 0", out_valid64, out_data64, out_err64);
        end
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready64 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b want 1", in_ready64);
        end
        base_del = n_del;
        sel64 = 6'd50; vld64 = 1'b1; rdy64 = 1'b1; chk_lat = 1'b1;
        tick();
        vld64 = 1'b0;
        drain("rst");
        n_checks++;
        if (n_del - base_del != 1) begin
            n_fail++;
            $display("FAIL rst_after: got %0d beats want 1", n_del - base_del);
        end
        chk_lat = 1'b0;
    endtask

    task automatic send5(input logic [2:0] s, input logic [7:0] ed, input logic ee, input string nm);
        int k;
        sel5 = s; vld5 = 1'b1;
        @(posedge clk);
        #1;
        vld5 = 1'b0;
        k = 1;
        while (!out_valid5 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k != 3 || out_data5 !== ed || out_err5 !== ee) begin
            n_fail++;
            $display("FAIL %s: got lat=%0d d=%h e=%b want lat=3 d=%h e=%b", nm, k, out_data5, out_err5, ed, ee);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ch5();
        rdy5 = 1'b1;
        send5(3'd4, 8'hA4, 1'b0, "ch5_sel4");
        send5(3'd6, 8'h00, ERR_EN, "ch5_sel6");
        send5(3'd7, 8'h00, ERR_EN, "ch5_sel7");
        send5(3'd0, 8'hA0, 1'b0, "ch5_sel0");
        send5(3'd5, 8'h00, ERR_EN, "ch5_sel5");
    endtask

    initial begin
        for (int c = 0; c < int'(CH); c++) in_data64[c*W +: W] = 8'(c + 1);
        in_data5 = 40'hA4A3A2A1A0;
        sel64 = '0; vld64 = 1'b0; rdy64 = 1'b1; fl64 = 1'b0;
        sel5 = '0; vld5 = 1'b0; rdy5 = 1'b1; fl5 = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_ch5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
